// File: rtl/jtagtest_pkg.sv
// Shared types for the JTAG-test serial link blocks.
package jtagtest_pkg;

  // Transmitter control states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

endpackage : jtagtest_pkg

// File: rtl/shift_tx_tick.sv
// Bit-period divider: a DIV-cycle down-counter with reload that produces a
// one-cycle tick on the last cycle of each period.
// Ports:
//   CLK, RESET    clock, synchronous active-high reset
//   load_i        start a new period (counter := DIV-1)
//   run_i         count down this cycle; reloads to DIV-1 after reaching 0
//   tick_o        registered tick, high while the counter sits at 0
//   tick_nxt_c_o  combinational next value of tick_o
module shift_tx_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic load_i,
  input  logic run_i,
  output logic tick_o,
  output logic tick_nxt_c_o
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] RELOAD = DW'(DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          tick_q;

  // Next counter value; the tick is registered so it lines up with div = 0.
  always_comb begin
    div_d = div_q;
    if (load_i) begin
      div_d = RELOAD;
    end else if (run_i) begin
      div_d = (div_q == '0) ? RELOAD : div_q - DW'(1);
    end
    tick_nxt_c_o = (load_i || run_i) && (div_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_nxt_c_o;
    end
  end

  assign tick_o = tick_q;

endmodule : shift_tx_tick

// File: rtl/shift_tx.sv
// Parallel-to-serial transmitter: accepts a SIZE-bit word on VALID & READY and
// shifts it out MSB first, one bit per DIV cycles, with a one-cycle SEN strobe
// on the last cycle of every bit period and DONE on the final strobe.
// Ports:
//   CLK, RESET  clock, synchronous active-high reset
//   DATA        word to send, sampled only on the accept cycle
//   VALID       DATA is valid
//   READY       combinational; high in IDLE and on the last-bit cycle
//   SOUT        registered serial data
//   SEN         registered bit strobe for the receiver
//   BUSY        registered, high while a word is shifting
//   DONE        registered, one-cycle pulse with the final SEN of a word
module shift_tx
  import jtagtest_pkg::*;
#(
  parameter int unsigned SIZE = 8,
  parameter int unsigned DIV  = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [SIZE-1:0] DATA,
  input  logic            VALID,
  output logic            READY,
  output logic            SOUT,
  output logic            SEN,
  output logic            BUSY,
  output logic            DONE
);

  localparam int unsigned BW = (SIZE > 2) ? $clog2(SIZE) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(SIZE - 1);

  tx_state_t       state_q, state_d;
  logic [SIZE-1:0] sr_q, sr_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            load, run;
  logic            tick, tick_nxt;
  logic            last_c, accept_c;

  shift_tx_tick #(.DIV(DIV)) u_tick (
    .CLK          (CLK),
    .RESET        (RESET),
    .load_i       (load),
    .run_i        (run),
    .tick_o       (tick),
    .tick_nxt_c_o (tick_nxt)
  );

  // Last-bit cycle: final strobe of the word, where a follow-on word may load.
  assign last_c   = (state_q == SHIFT) && tick && (cnt_q == '0);
  assign READY    = !RESET && ((state_q == IDLE) || last_c);
  assign accept_c = READY && VALID;

  // Next-state, shift register and bit counter.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    run     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = SHIFT;
          sr_d    = DATA;
          cnt_d   = LAST_BIT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (last_c) begin
          if (accept_c) begin
            sr_d  = DATA;
            cnt_d = LAST_BIT;
            load  = 1'b1;
          end else begin
            state_d = IDLE;
            sr_d    = '0;
          end
        end else begin
          run = 1'b1;
          if (tick) begin
            sr_d  = {sr_q[SIZE-2:0], 1'b0};
            cnt_d = cnt_q - BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // DONE is registered: it rises when the upcoming strobe is the last bit.
  assign done_d = tick_nxt && (cnt_d == '0) && (state_d == SHIFT);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // The shift register is cleared on entry to IDLE, so its MSB is 0 there.
  assign SOUT = sr_q[SIZE-1];
  assign SEN  = tick;
  assign BUSY = (state_q == SHIFT);
  assign DONE = done_q;

endmodule : shift_tx

// File: tb/tb_shift_tx.sv
module tb_shift_tx;

  localparam int unsigned SIZE = 8;
  localparam int unsigned DIV  = 4;
  localparam int WL = SIZE * DIV;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] DATA;
  logic       VALID;
  logic       READY, SOUT, SEN, BUSY, DONE;
  logic [7:0] DATA1;
  logic       VALID1;
  logic       READY1, SOUT1, SEN1, BUSY1, DONE1;

  always #5 CLK = ~CLK;

  shift_tx #(.SIZE(SIZE), .DIV(DIV)) dut (
    .CLK(CLK), .RESET(RESET), .DATA(DATA), .VALID(VALID), .READY(READY),
    .SOUT(SOUT), .SEN(SEN), .BUSY(BUSY), .DONE(DONE)
  );

  shift_tx #(.SIZE(8), .DIV(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .DATA(DATA1), .VALID(VALID1), .READY(READY1),
    .SOUT(SOUT1), .SEN(SEN1), .BUSY(BUSY1), .DONE(DONE1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: one word in flight, outputs derived from accept time.
  bit         m_busy = 1'b0;
  int         m_t    = 0;
  logic [7:0] m_word = '0;
  logic [7:0] sent_q[$];
  logic [7:0] cap    = '0;
  int         sen_seen  = 0;
  int         done_seen = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [4:0] exp;   // {SOUT, SEN, DONE, BUSY, READY}
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle on the DIV=4 instance, checked against the model.
  task automatic tick_cycle(input logic v, input logic [7:0] d, input logic rst,
                            output bit acc);
    int         off;
    logic [4:0] e;
    RESET = rst;
    VALID = v;
    DATA  = d;
    @(negedge CLK);
    off = cyc - m_t;
    if (m_busy)
      e = {m_word[SIZE-1-(off-1)/DIV], (off % DIV) == 0, off == WL, 1'b1,
           (off == WL) && !rst};
    else
      e = {4'b0000, !rst};
    chk("outputs{sout,sen,done,busy,ready}", {27'b0, SOUT, SEN, DONE, BUSY, READY},
        {27'b0, e});
    // Loopback receiver: left-shifting capture register enabled by SEN.
    if (SEN === 1'b1) begin
      cap = {cap[6:0], SOUT};
      sen_seen++;
    end
    if (DONE === 1'b1) begin
      done_seen++;
      chk("capture_pending", 32'(sent_q.size() != 0), 32'd1);
      if (sent_q.size() != 0) chk("capture_word", {24'b0, cap}, {24'b0, sent_q.pop_front()});
    end
    acc = 1'b0;
    if (rst) begin
      if (m_busy && off != WL && sent_q.size() != 0) void'(sent_q.pop_back());
      m_busy = 1'b0;
    end else if (e[0] && v) begin
      m_busy = 1'b1;
      m_t    = cyc;
      m_word = d;
      sent_q.push_back(d);
      acc = 1'b1;
    end else if (m_busy && off == WL) begin
      m_busy = 1'b0;
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    bit   acc;
    int   s0, d0;
    vec_t tbl[10];

    RESET = 1'b1; VALID = 1'b0; DATA = '0; VALID1 = 1'b0; DATA1 = '0;
    repeat (2) @(posedge CLK);
    #1;
    cyc = 0;
    tick_cycle(1'b1, 8'h00, 1'b1, acc);  // reset state, READY low under RESET

    // Single word 8'hA5 accepted at cycle 10, DATA churning during SHIFT.
    while (cyc < 10) tick_cycle(1'b0, 8'($urandom), 1'b0, acc);
    tick_cycle(1'b1, 8'hA5, 1'b0, acc);
    repeat (WL + 1) tick_cycle(1'b0, 8'($urandom), 1'b0, acc);
    for (int i = 0; i < 4; i++) tick_cycle(1'b1, 8'($urandom), 1'b0, acc); // warm-up words
    repeat (WL + 4) tick_cycle(1'b0, 8'h00, 1'b0, acc);
    for (int i = 0; i < 6; i++) tick_cycle(1'b0, 8'($urandom), 1'b0, acc);

    // Back-to-back: A5 then 3C with VALID held high.
    s0 = sen_seen; d0 = done_seen;
    tick_cycle(1'b1, 8'hA5, 1'b0, acc);
    repeat (WL) tick_cycle(1'b1, 8'h3C, 1'b0, acc);
    repeat (WL + 2) tick_cycle(1'b0, 8'h00, 1'b0, acc);
    chk("b2b_sen_count", 32'(sen_seen - s0), 32'd16);
    chk("b2b_done_count", 32'(done_seen - d0), 32'd2);

    // Reset 10 cycles into a word, then a clean word right after.
    tick_cycle(1'b1, 8'h5A, 1'b0, acc);
    repeat (9) tick_cycle(1'b0, 8'h00, 1'b0, acc);
    d0 = done_seen;
    tick_cycle(1'b1, 8'hFF, 1'b1, acc);
    tick_cycle(1'b1, 8'hC3, 1'b0, acc);
    chk("accept_after_reset", 32'(acc), 32'd1);
    repeat (WL + 1) tick_cycle(1'b0, 8'h00, 1'b0, acc);
    chk("aborted_no_done", 32'(done_seen - d0), 32'd1);

    // DIV=1 instance: 8'h81, DATA changed while shifting.
    tbl[0] = '{1'b1, 8'h81, 5'b00001};
    tbl[1] = '{1'b0, 8'hFF, 5'b11010};
    for (int i = 2; i < 8; i++) tbl[i] = '{1'b1, 8'h7E, 5'b01010};
    tbl[8] = '{1'b0, 8'h00, 5'b11111};
    tbl[9] = '{1'b0, 8'h00, 5'b00001};
    RESET = 1'b0; VALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      VALID1 = tbl[i].v;
      DATA1  = tbl[i].d;
      @(negedge CLK);
      chk($sformatf("div1_row%0d", i), {27'b0, SOUT1, SEN1, DONE1, BUSY1, READY1},
          {27'b0, tbl[i].exp});
      @(posedge CLK);
      #1;
      cyc++;
    end
    VALID1 = 1'b0;

    // Random words with random gaps, reconstructed through the loopback.
    for (int w = 0; w < 200; w++) begin
      int         g, guard;
      logic [7:0] d;
      g = $urandom_range(0, 3);
      repeat (g) tick_cycle(1'b0, 8'($urandom), 1'b0, acc);
      d = 8'($urandom);
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 2 * WL) begin
        tick_cycle(1'b1, d, 1'b0, acc);
        guard++;
      end
      if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    end
    repeat (WL + 2) tick_cycle(1'b0, 8'h00, 1'b0, acc);
    chk("all_words_delivered", 32'(sent_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_shift_tx
